// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM states, flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_SLT = 4'hC;
  localparam logic [3:0] OP_SGT = 4'hD;
  localparam logic [3:0] OP_LUI = 4'hE;
  localparam logic [3:0] OP_HAM = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } alu_flags_t;

  // Shifts and popcount run on the iterative datapath; everything else is one cycle.
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_HAM);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: variable shifts (STEP bits per cycle) and Hamming distance
// (popcount of a^b, STEP bits per cycle). Loaded on start; done while cnt==0.
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] acc
);

  localparam int KW = $clog2(WIDTH);
  localparam int CW = KW + 1;
  localparam int SL = $clog2(STEP);

  logic             run_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    rem_q;

  logic [CW-1:0]    kk;
  logic [CW-1:0]    shift_cnt;
  logic [CW-1:0]    amt;
  logic [CW-1:0]    pc;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] ham_nxt;

  assign kk        = CW'(b[KW-1:0]);
  assign shift_cnt = (kk + CW'(STEP - 1)) >> SL;
  assign done      = run_q && (cnt_q == '0);
  assign acc       = acc_q;

  // Next shift step: the last step may move fewer than STEP bits.
  always_comb begin
    amt    = (rem_q < CW'(STEP)) ? rem_q : CW'(STEP);
    sh_nxt = acc_q;
    case (op_q)
      OP_SLL:  sh_nxt = acc_q << amt;
      OP_SRL:  sh_nxt = acc_q >> amt;
      OP_SRA:  sh_nxt = $signed(acc_q) >>> amt;
      default: sh_nxt = acc_q;
    endcase
  end

  // Popcount of the low STEP bits of the remaining a^b word.
  always_comb begin
    pc = '0;
    for (int i = 0; i < STEP; i++) pc = pc + CW'(x_q[i]);
    ham_nxt = acc_q + WIDTH'(pc);
  end

  // Load on start, then one step per cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      op_q  <= '0;
      acc_q <= '0;
      x_q   <= '0;
      cnt_q <= '0;
      rem_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      op_q  <= op;
      if (op == OP_HAM) begin
        acc_q <= '0;
        x_q   <= a ^ b;
        cnt_q <= CW'(WIDTH / STEP);
        rem_q <= '0;
      end else begin
        acc_q <= a;
        x_q   <= '0;
        cnt_q <= shift_cnt;
        rem_q <= kk;
      end
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
        if (op_q == OP_HAM) begin
          acc_q <= ham_nxt;
          x_q   <= x_q >> STEP;
        end else begin
          acc_q <= sh_nxt;
          rem_q <= rem_q - amt;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Operands are latched on accept;
// the result and flags are registered on the completing BUSY cycle and held in DONE.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             iter_q;
  logic             accept;
  logic             complete;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_acc;

  logic [WIDTH:0]   sum, dif, inc, dec;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       fl_c, fl_q;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid  = (state_q == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter(opcode);
  assign complete   = (state_q == ST_BUSY) && (!iter_q || iter_done);
  assign flag_zero  = fl_q.zero;
  assign flag_carry = fl_q.carry;
  assign flag_ovf   = fl_q.ovf;

  alu_mc_iter #(.WIDTH(WIDTH), .STEP(STEP)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .op    (opcode),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a DONE that is drained with a new request goes straight back to BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_BUSY;
      ST_BUSY: if (complete)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operand capture, only on an accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      iter_q <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= opcode;
      iter_q <= is_iter(opcode);
    end
  end

  // Single-cycle ops from latched operands; iterative ops take the iter accumulator.
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    dif   = {1'b0, a_q} - {1'b0, b_q};
    inc   = {1'b0, a_q} + 1'b1;
    dec   = {1'b0, a_q} - 1'b1;
    res_c = '0;
    fl_c  = '0;
    case (op_q)
      OP_ADD: begin
        res_c      = sum[MSB:0];
        fl_c.carry = sum[WIDTH];
        fl_c.ovf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_c      = dif[MSB:0];
        fl_c.carry = dif[WIDTH];
        fl_c.ovf   = (a_q[MSB] != b_q[MSB]) && (dif[MSB] != a_q[MSB]);
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOR: res_c = ~(a_q | b_q);
      OP_NOT: res_c = ~a_q;
      OP_INC: begin
        res_c      = inc[MSB:0];
        fl_c.carry = inc[WIDTH];
        fl_c.ovf   = !a_q[MSB] && inc[MSB];
      end
      OP_DEC: begin
        res_c      = dec[MSB:0];
        fl_c.carry = dec[WIDTH];
        fl_c.ovf   = a_q[MSB] && !dec[MSB];
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SGT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
      OP_LUI: res_c = b_q << (WIDTH / 2);
      default: res_c = iter_acc;
    endcase
    fl_c.zero = (res_c == '0);
  end

  // Result/flag register: loaded once per operation, held through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      fl_q   <= '0;
    end else if (complete) begin
      result <= res_c;
      fl_q   <= fl_c;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed table, random ops against a behavioural model,
// backpressure / same-edge handoff, mid-operation reset, and a STEP=8 instance.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid8, out_ready, out_ready8;
  logic [31:0] a, b;
  logic [3:0]  opcode;
  logic        in_ready, out_valid, fz, fc, fv;
  logic [31:0] result;
  logic        in_ready8, out_valid8, fz8, fc8, fv8;
  logic [31:0] result8;
  logic        sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(fz), .flag_carry(fc), .flag_ovf(fv));

  alu_mc #(.WIDTH(32), .STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_zero(fz8), .flag_carry(fc8), .flag_ovf(fv8));

  wire        m_ir  = sel ? in_ready8  : in_ready;
  wire        m_ov  = sel ? out_valid8 : out_valid;
  wire [31:0] m_res = sel ? result8    : result;
  wire        m_z   = sel ? fz8 : fz;
  wire        m_c   = sel ? fc8 : fc;
  wire        m_v   = sel ? fv8 : fv;

  typedef struct {
    logic [31:0] r;
    logic        z, c, v;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        z, c, v;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural reference: wide integer arithmetic and range checks.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] av,
                                 input logic [31:0] bv, input int step);
    exp_t        e;
    longint      ua, ub, full, sa, sb, sr;
    int          k, cnt;
    logic [31:0] x;
    ua = longint'({32'b0, av});
    ub = longint'({32'b0, bv});
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    k  = int'(bv[4:0]);
    e.r = 32'h0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
    full = 0; sr = 0;
    case (op)
      OP_ADD: begin full = ua + ub; sr = sa + sb; end
      OP_SUB: begin full = ua - ub; sr = sa - sb; end
      OP_INC: begin full = ua + 1;  sr = sa + 1;  end
      OP_DEC: begin full = ua - 1;  sr = sa - 1;  end
      default: ;
    endcase
    case (op)
      OP_ADD, OP_INC: begin e.r = full[31:0]; e.c = (full > 64'hFFFF_FFFF); end
      OP_SUB: begin e.r = full[31:0]; e.c = (ua < ub); end
      OP_DEC: begin e.r = full[31:0]; e.c = (ua < 1); end
      OP_AND: e.r = av & bv;
      OP_OR:  e.r = av | bv;
      OP_XOR: e.r = av ^ bv;
      OP_NOR: e.r = ~(av | bv);
      OP_NOT: e.r = ~av;
      OP_SLL: begin e.r = av << k; e.lat = 1 + (k + step - 1) / step; end
      OP_SRL: begin e.r = av >> k; e.lat = 1 + (k + step - 1) / step; end
      OP_SRA: begin e.r = $signed(av) >>> k; e.lat = 1 + (k + step - 1) / step; end
      OP_SLT: e.r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SGT: e.r = (sa > sb) ? 32'd1 : 32'd0;
      OP_LUI: begin x = bv << 16; e.r = x; end
      default: begin
        x = av ^ bv; cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(x[i]);
        e.r = 32'(cnt); e.lat = 1 + 32 / step;
      end
    endcase
    if (op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC})
      e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z = (e.r == 32'h0);
    return e;
  endfunction

  // One complete transaction on the selected instance; latency counted in edges after accept.
  task automatic run_op(input logic s, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output exp_t got, output int rdy_busy,
                        output logic ir0);
    int lat;
    @(negedge clk);
    sel = s; opcode = op; a = av; b = bv;
    if (s) in_valid8 = 1'b1; else in_valid = 1'b1;
    #1 ir0 = m_ir;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_valid8 = 1'b0;
    lat = 0; rdy_busy = 0;
    while (!m_ov && lat < 200) begin
      if (m_ir) rdy_busy++;
      @(negedge clk);
      lat++;
    end
    got.r = m_res; got.z = m_z; got.c = m_c; got.v = m_v; got.lat = lat;
    if (s) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready8 = 1'b0;
  endtask

  task automatic cmp(input string tag, input exp_t got, input exp_t e,
                     input int rdy_busy, input logic ir0);
    chk({tag, " in_ready_idle"}, 64'(ir0), 64'd1);
    chk({tag, " result"}, 64'(got.r), 64'(e.r));
    chk({tag, " zero"}, 64'(got.z), 64'(e.z));
    chk({tag, " carry"}, 64'(got.c), 64'(e.c));
    chk({tag, " ovf"}, 64'(got.v), 64'(e.v));
    chk({tag, " latency"}, 64'(got.lat), 64'(e.lat));
    chk({tag, " in_ready_busy"}, 64'(rdy_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[15];
    exp_t        got, e;
    int          rb, lat, seen;
    logic        ir0;
    logic [3:0]  op;
    logic [31:0] ra, rbv;

    tbl[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    tbl[1]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    tbl[2]  = '{OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5};
    tbl[3]  = '{OP_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 32};
    tbl[4]  = '{OP_SRL, 32'h00000002, 32'h00000000, 32'h00000002, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{OP_HAM, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000020, 1'b0, 1'b0, 1'b0, 33};
    tbl[6]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{OP_SGT, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{OP_LUI, 32'h12345678, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{OP_DEC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{OP_INC, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    tbl[11] = '{OP_DEC, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    tbl[12] = '{OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    tbl[13] = '{OP_SRA, 32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 1'b0, 1'b0, 1'b0, 2};
    tbl[14] = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};

    sel = 1'b0; rst_n = 1'b0;
    in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0; out_ready8 = 1'b0;
    a = '0; b = '0; opcode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset flags", 64'({fz, fc, fv}), 64'd0);
    chk("reset out_valid8", 64'(out_valid8), 64'd0);
    chk("reset result8", 64'(result8), 64'd0);

    // Directed table on the STEP=1 instance.
    for (int i = 0; i < 15; i++) begin
      run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, got, rb, ir0);
      e.r = tbl[i].r; e.z = tbl[i].z; e.c = tbl[i].c; e.v = tbl[i].v; e.lat = tbl[i].lat;
      cmp($sformatf("vec%0d", i), got, e, rb, ir0);
    end

    // HAM on the STEP=8 instance: same count, 1 + 32/8 edges.
    run_op(1'b1, OP_HAM, 32'hF0F0F0F0, 32'h0F0F0F0F, got, rb, ir0);
    e.r = 32'h20; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.lat = 5;
    cmp("ham_step8", got, e, rb, ir0);

    // Random ops against the model, both instances.
    for (int i = 0; i < 200; i++) begin
      op  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rbv = $urandom;
      if (i % 7 == 0) ra  = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
      if (i % 9 == 0) rbv = 32'($urandom_range(0, 1));
      run_op(i % 5 == 4, op, ra, rbv, got, rb, ir0);
      e = model(op, ra, rbv, (i % 5 == 4) ? 8 : 1);
      cmp($sformatf("rnd%0d op%0h", i, op), got, e, rb, ir0);
    end

    // Backpressure: SUB 2-1 held for 3 cycles, then handoff to AND 3&1 on one edge.
    @(negedge clk);
    sel = 1'b0; opcode = OP_SUB; a = 32'd2; b = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("bp sub latency", 64'(lat), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp hold%0d result", i), 64'(result), 64'd1);
      chk($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; opcode = OP_AND; a = 32'd3; b = 32'd1;
    #1 chk("bp handoff in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp after handoff out_valid", 64'(out_valid), 64'd0);
    chk("bp after handoff in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp and out_valid", 64'(out_valid), 64'd1);
    chk("bp and result", 64'(result), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp drained out_valid", 64'(out_valid), 64'd0);

    // Leave a nonzero result registered, then reset in the middle of a HAM.
    run_op(1'b0, OP_ADD, 32'hFFFFFFFF, 32'h00000001, got, rb, ir0);
    run_op(1'b0, OP_NOT, 32'h0000FFFF, 32'h0, got, rb, ir0);
    chk("pre-reset result", 64'(got.r), 64'hFFFF0000);
    @(negedge clk);
    opcode = OP_HAM; a = 32'hFFFFFFFF; b = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset result", 64'(result), 64'd0);
    chk("midreset flags", 64'({fz, fc, fv}), 64'd0);
    rst_n = 1'b1;
    #1 chk("midreset in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset stale outputs", 64'(seen), 64'd0);
    run_op(1'b0, OP_ADD, 32'd5, 32'd6, got, rb, ir0);
    e = model(OP_ADD, 32'd5, 32'd6, 1);
    cmp("post-reset add", got, e, rb, ir0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
